// File: rtl/puf_rng_pkg.sv
// Shared types and constants for the arbiter-PUF challenge sequencer.
package puf_rng_pkg;

  localparam int LFSR_W = 64;

  // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_SETTLE,
    S_SAMPLE,
    S_OUTPUT
  } seq_state_t;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Chain-side (challenge/launch/resp) and downstream word handshake bundle.
interface puf_challenge_sequencer_if #(
  parameter int N_STAGES = 64,
  parameter int OUT_W    = 32
);
  logic [N_STAGES-1:0] challenge;
  logic                launch;
  logic                resp;
  logic [OUT_W-1:0]    rnd_data;
  logic                rnd_valid;
  logic                rnd_ready;

  modport master (
    output challenge, launch, rnd_data, rnd_valid,
    input  resp, rnd_ready
  );

  modport slave (
    input  challenge, launch, rnd_data, rnd_valid,
    output resp, rnd_ready
  );
endinterface

// File: rtl/puf_lfsr64.sv
// 64-bit Fibonacci LFSR, left-shifting with feedback into bit 0; advances on step.
module puf_lfsr64
  import puf_rng_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d, seed_eff;

  // An all-zero state would lock the register up.
  assign seed_eff = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

  always_comb begin
    q_d = q_q;
    if (step) q_d = {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= seed_eff;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Runs arbiter-PUF trials (load challenge, launch, settle, sample), optionally
// von Neumann debiases the response bits and packs them into OUT_W-bit words.
module puf_challenge_sequencer
  import puf_rng_pkg::*;
#(
  parameter int          N_STAGES = 64,
  parameter int          OUT_W    = 32,
  parameter int          SETTLE   = 8,
  parameter logic [63:0] SEED     = 64'h1,
  parameter int          DEBIAS   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  puf_challenge_sequencer_if.master bus
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BC_W  = $clog2(OUT_W + 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic              pair_q, pair_d;
  logic              first_q, first_d;
  logic              launch_q, launch_d;
  logic              valid_q, valid_d;
  logic              step;
  logic              take;
  logic              bitv;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;

  puf_lfsr64 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .seed (SEED),
    .q    (lfsr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    word_d   = word_q;
    pair_d   = pair_q;
    first_d  = first_q;
    launch_d = 1'b0;
    valid_d  = valid_q;
    step     = 1'b0;
    take     = 1'b0;
    bitv     = 1'b0;

    case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        step     = 1'b1;
        launch_d = 1'b1;
        state_d  = S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_d   = CNT_W'(SETTLE - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SAMPLE: begin
        if (DEBIAS == 0) begin
          take = 1'b1;
          bitv = bus.resp;
        end else if (!pair_q) begin
          first_d = bus.resp;
          pair_d  = 1'b1;
        end else begin
          // 01 -> 0, 10 -> 1: the emitted bit is the first of the pair.
          pair_d = 1'b0;
          take   = (first_q != bus.resp);
          bitv   = first_q;
        end
        if (take) begin
          word_d   = (word_q << 1) | OUT_W'(bitv);
          bitcnt_d = bitcnt_q + 1'b1;
        end
        if (bitcnt_d == BC_W'(OUT_W)) begin
          valid_d = 1'b1;
          state_d = S_OUTPUT;
        end else begin
          state_d = en ? S_LOAD : S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (bus.rnd_ready) begin
          word_d   = '0;
          bitcnt_d = '0;
          pair_d   = 1'b0;
          first_d  = 1'b0;
          valid_d  = 1'b0;
          state_d  = en ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      word_q   <= '0;
      pair_q   <= 1'b0;
      first_q  <= 1'b0;
      launch_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      word_q   <= word_d;
      pair_q   <= pair_d;
      first_q  <= first_d;
      launch_q <= launch_d;
      valid_q  <= valid_d;
    end
  end

  // The LFSR only steps in LOAD, so the challenge is frozen for the whole race.
  assign bus.challenge = lfsr[N_STAGES-1:0];
  assign bus.launch    = launch_q;
  assign bus.rnd_valid = valid_q;
  assign bus.rnd_data  = word_q;
  assign lfsr_unused   = ^lfsr;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench: raw-mode instance (OUT_W=4) and debiased instance (OUT_W=2).
module tb_puf_challenge_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en0, en1;
  int   tests = 0, fails = 0;
  logic [15:0] rtab0, rtab1;
  int   idx0, idx1, lcnt0, lcnt1;

  puf_challenge_sequencer_if #(.N_STAGES(8), .OUT_W(4)) if0 ();
  puf_challenge_sequencer_if #(.N_STAGES(8), .OUT_W(2)) if1 ();

  puf_challenge_sequencer #(.N_STAGES(8), .OUT_W(4), .SETTLE(2), .SEED(64'h1), .DEBIAS(0))
    u0 (.clk(clk), .rst(rst), .en(en0), .bus(if0));
  puf_challenge_sequencer #(.N_STAGES(8), .OUT_W(2), .SETTLE(2), .SEED(64'h1), .DEBIAS(1))
    u1 (.clk(clk), .rst(rst), .en(en1), .bus(if1));

  // One clock; on each launch, present the next table bit as that trial's response.
  task automatic step();
    @(posedge clk); #1;
    if (if0.launch === 1'b1) begin if0.resp = rtab0[idx0]; idx0++; lcnt0++; end
    if (if1.launch === 1'b1) begin if1.resp = rtab1[idx1]; idx1++; lcnt1++; end
  endtask

  task automatic do_reset();
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
    if0.resp = 1'b0; if1.resp = 1'b0; if0.rnd_ready = 1'b0; if1.rnd_ready = 1'b0;
    idx0 = 0; idx1 = 0; lcnt0 = 0; lcnt1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (if0.challenge !== 8'h01) begin fails++; $display("FAIL reset_challenge got %h exp 01", if0.challenge); end
    tests++; if (if0.launch !== 1'b0) begin fails++; $display("FAIL reset_launch got %b exp 0", if0.launch); end
    tests++; if (if0.rnd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", if0.rnd_valid); end
    tests++; if (if0.rnd_data !== 4'h0) begin fails++; $display("FAIL reset_data got %h exp 0", if0.rnd_data); end
    tests++; if (if1.challenge !== 8'h01) begin fails++; $display("FAIL reset_challenge1 got %h exp 01", if1.challenge); end
  endtask

  task automatic test_raw();
    int prev = -1, bad_int = 0, vcyc = -1;
    do_reset();
    rtab0 = 16'hFFFF; if0.resp = 1'b1; if0.rnd_ready = 1'b1; en0 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) begin
        tests++; if (if0.challenge !== 8'h01) begin fails++; $display("FAIL raw_chal_idle got %h exp 01", if0.challenge); end
      end
      if (i == 2) begin
        tests++; if (if0.challenge !== 8'h02) begin fails++; $display("FAIL raw_chal_load got %h exp 02", if0.challenge); end
        tests++; if (if0.launch !== 1'b1) begin fails++; $display("FAIL raw_first_launch got %b exp 1", if0.launch); end
      end
      if (if0.launch === 1'b1) begin
        if (prev >= 0 && i - prev != 5) bad_int++;
        prev = i;
      end
      if (if0.rnd_valid === 1'b1) begin vcyc = i; break; end
    end
    tests++; if (vcyc != 21) begin fails++; $display("FAIL raw_latency got %0d exp 21", vcyc); end
    tests++; if (if0.rnd_data !== 4'hF) begin fails++; $display("FAIL raw_data got %h exp f", if0.rnd_data); end
    tests++; if (lcnt0 != 4) begin fails++; $display("FAIL raw_launches got %0d exp 4", lcnt0); end
    tests++; if (bad_int != 0) begin fails++; $display("FAIL raw_launch_period got %0d bad exp 0", bad_int); end
    tests++; if (if0.challenge !== 8'h10) begin fails++; $display("FAIL raw_chal_end got %h exp 10", if0.challenge); end
    step();
    tests++; if (if0.rnd_valid !== 1'b0) begin fails++; $display("FAIL raw_valid_drop got %b exp 0", if0.rnd_valid); end
    tests++; if (if0.rnd_data !== 4'h0) begin fails++; $display("FAIL raw_word_clear got %h exp 0", if0.rnd_data); end
    step();
    tests++; if (if0.launch !== 1'b1) begin fails++; $display("FAIL raw_back_to_back got %b exp 1", if0.launch); end
    en0 = 1'b0;
  endtask

  task automatic test_backpressure();
    int bp_err = 0;
    bit found = 0;
    do_reset();
    rtab0 = 16'h000D; en0 = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (if0.rnd_valid === 1'b1) found = 1;
    end
    tests++; if (!found) begin fails++; $display("FAIL bp_timeout got no valid exp valid"); end
    tests++; if (if0.rnd_data !== 4'hB) begin fails++; $display("FAIL bp_data got %h exp b", if0.rnd_data); end
    tests++; if (if0.challenge !== 8'h10) begin fails++; $display("FAIL bp_chal got %h exp 10", if0.challenge); end
    for (int i = 0; i < 10; i++) begin
      step();
      if (if0.launch !== 1'b0 || if0.challenge !== 8'h10 || if0.rnd_data !== 4'hB || if0.rnd_valid !== 1'b1)
        bp_err++;
    end
    tests++; if (bp_err != 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles exp 0", bp_err); end
    tests++; if (lcnt0 != 4) begin fails++; $display("FAIL bp_launches got %0d exp 4", lcnt0); end
    if0.rnd_ready = 1'b1;
    step();
    tests++; if (if0.rnd_valid !== 1'b0) begin fails++; $display("FAIL bp_accept got %b exp 0", if0.rnd_valid); end
    step();
    tests++; if (if0.launch !== 1'b1) begin fails++; $display("FAIL bp_resume_launch got %b exp 1", if0.launch); end
    tests++; if (if0.challenge !== 8'h20) begin fails++; $display("FAIL bp_resume_chal got %h exp 20", if0.challenge); end
    en0 = 1'b0;
  endtask

  task automatic test_en_drop();
    bit found = 0;
    do_reset();
    rtab0 = 16'h000D; if0.rnd_ready = 1'b1; en0 = 1'b1;
    for (int i = 0; i < 10 && lcnt0 == 0; i++) step();
    tests++; if (lcnt0 != 1) begin fails++; $display("FAIL drop_first_launch got %0d exp 1", lcnt0); end
    step();
    en0 = 1'b0;
    repeat (8) step();
    tests++; if (lcnt0 != 1) begin fails++; $display("FAIL drop_parked got %0d launches exp 1", lcnt0); end
    tests++; if (if0.rnd_data !== 4'h1) begin fails++; $display("FAIL drop_kept got %h exp 1", if0.rnd_data); end
    tests++; if (if0.rnd_valid !== 1'b0) begin fails++; $display("FAIL drop_valid got %b exp 0", if0.rnd_valid); end
    tests++; if (if0.challenge !== 8'h02) begin fails++; $display("FAIL drop_chal got %h exp 02", if0.challenge); end
    en0 = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (if0.rnd_valid === 1'b1) found = 1;
    end
    tests++; if (!found) begin fails++; $display("FAIL drop_timeout got no valid exp valid"); end
    tests++; if (if0.rnd_data !== 4'hB) begin fails++; $display("FAIL drop_resume_data got %h exp b", if0.rnd_data); end
    tests++; if (lcnt0 != 4) begin fails++; $display("FAIL drop_resume_launches got %0d exp 4", lcnt0); end
    en0 = 1'b0;
  endtask

  task automatic test_reset_settle();
    do_reset();
    rtab0 = 16'hFFFF; if0.rnd_ready = 1'b1; en0 = 1'b1;
    for (int i = 0; i < 20 && lcnt0 < 2; i++) step();
    step();
    tests++; if (if0.rnd_data !== 4'h1) begin fails++; $display("FAIL rs_pre_data got %h exp 1", if0.rnd_data); end
    tests++; if (if0.challenge !== 8'h04) begin fails++; $display("FAIL rs_pre_chal got %h exp 04", if0.challenge); end
    #2 rst = 1'b1; en0 = 1'b0;
    #1;
    tests++; if (if0.challenge !== 8'h01) begin fails++; $display("FAIL rs_async_chal got %h exp 01", if0.challenge); end
    tests++; if (if0.rnd_data !== 4'h0) begin fails++; $display("FAIL rs_async_data got %h exp 0", if0.rnd_data); end
    tests++; if (if0.launch !== 1'b0 || if0.rnd_valid !== 1'b0) begin fails++; $display("FAIL rs_async_ctl got %b%b exp 00", if0.launch, if0.rnd_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; lcnt0 = 0;
    repeat (5) step();
    tests++; if (lcnt0 != 0 || if0.challenge !== 8'h01) begin fails++; $display("FAIL rs_idle got %0d/%h exp 0/01", lcnt0, if0.challenge); end
    en0 = 1'b1;
    step(); step();
    tests++; if (if0.launch !== 1'b1 || if0.challenge !== 8'h02) begin fails++; $display("FAIL rs_restart got %b/%h exp 1/02", if0.launch, if0.challenge); end
    en0 = 1'b0;
  endtask

  task automatic test_debias();
    int vcyc = -1;
    do_reset();
    rtab1 = 16'h001E; en1 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (if1.rnd_valid === 1'b1) begin vcyc = i; break; end
    end
    tests++; if (vcyc != 31) begin fails++; $display("FAIL vn_latency got %0d exp 31", vcyc); end
    tests++; if (if1.rnd_data !== 2'b01) begin fails++; $display("FAIL vn_data got %b exp 01", if1.rnd_data); end
    tests++; if (lcnt1 != 6) begin fails++; $display("FAIL vn_launches got %0d exp 6", lcnt1); end
    if1.rnd_ready = 1'b1;
    step();
    tests++; if (if1.rnd_valid !== 1'b0 || if1.rnd_data !== 2'b00) begin fails++; $display("FAIL vn_accept got %b/%b exp 0/00", if1.rnd_valid, if1.rnd_data); end
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_backpressure();
    test_en_drop();
    test_reset_settle();
    test_debias();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
